// File: rtl/capture_ctrl.sv
// Sample-RAM capture sequencer: fills pre-trigger history in a circular buffer,
// arms, accepts a trigger, then writes trig_pos post-trigger samples and halts.
module capture_ctrl #(
    parameter int ADDR_W = 9
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              run,
    input  logic              abort,
    input  logic              wrt_smpl,
    input  logic              trig_in,
    input  logic [ADDR_W-1:0] trig_pos,
    output logic              we,
    output logic [ADDR_W-1:0] waddr,
    output logic              armed,
    output logic              triggered,
    output logic              capture_done,
    output logic [ADDR_W-1:0] trig_addr
);

    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(2**ADDR_W);

    typedef enum logic [2:0] {IDLE, FILL, ARMED, POST, DONE} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] waddr_q, waddr_d;
    logic [ADDR_W-1:0] trig_addr_q, trig_addr_d;
    logic [ADDR_W-1:0] post_cnt_q, post_cnt_d;
    logic [ADDR_W-1:0] trig_pos_q, trig_pos_d;
    logic [ADDR_W:0]   pre_cnt_q, pre_cnt_d;
    logic [ADDR_W:0]   pre_inc;
    logic [ADDR_W:0]   arm_thresh;
    logic [ADDR_W-1:0] post_inc;
    logic              we_c;

    // pre_cnt saturates at DEPTH so long fills never wrap back below the arm threshold
    assign pre_inc    = (pre_cnt_q == DEPTH_L) ? pre_cnt_q : pre_cnt_q + (ADDR_W+1)'(1);
    assign arm_thresh = DEPTH_L - {1'b0, trig_pos_q};
    assign post_inc   = post_cnt_q + ADDR_W'(1);

    always_comb begin
        state_d     = state_q;
        waddr_d     = waddr_q;
        trig_addr_d = trig_addr_q;
        post_cnt_d  = post_cnt_q;
        trig_pos_d  = trig_pos_q;
        pre_cnt_d   = pre_cnt_q;
        we_c        = 1'b0;

        if (abort) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (run) begin
                        waddr_d    = '0;
                        pre_cnt_d  = '0;
                        post_cnt_d = '0;
                        trig_pos_d = trig_pos;
                        state_d    = FILL;
                    end
                end
                FILL: begin
                    we_c = wrt_smpl;
                    if (wrt_smpl) begin
                        pre_cnt_d = pre_inc;
                        if (pre_inc >= arm_thresh) state_d = ARMED;
                    end
                end
                ARMED: begin
                    we_c = wrt_smpl;
                    if (trig_in) begin
                        // skip past a coincident sample: it belongs to pre-trigger history
                        trig_addr_d = waddr_q + ADDR_W'(wrt_smpl);
                        post_cnt_d  = '0;
                        state_d     = POST;
                    end
                end
                POST: begin
                    if (trig_pos_q == '0) begin
                        state_d = DONE;
                    end else begin
                        we_c = wrt_smpl;
                        if (wrt_smpl) begin
                            post_cnt_d = post_inc;
                            if (post_inc == trig_pos_q) state_d = DONE;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        if (we_c) waddr_d = waddr_q + ADDR_W'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            waddr_q     <= '0;
            trig_addr_q <= '0;
            post_cnt_q  <= '0;
            trig_pos_q  <= '0;
            pre_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            waddr_q     <= waddr_d;
            trig_addr_q <= trig_addr_d;
            post_cnt_q  <= post_cnt_d;
            trig_pos_q  <= trig_pos_d;
            pre_cnt_q   <= pre_cnt_d;
        end
    end

    assign we           = we_c;
    assign waddr        = waddr_q;
    assign trig_addr    = trig_addr_q;
    assign armed        = (state_q == ARMED);
    assign triggered    = (state_q == POST) || (state_q == DONE);
    assign capture_done = (state_q == DONE);

endmodule
